// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core control path and the multiply/divide unit.
//   master: start, kill, funct3, rs1_data, rs2_data, rd_in -> ; <- busy, done, result, rd_out
//   slave : the unit side of the same signals.
interface muldiv_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic            kill;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, kill, funct3, rs1_data, rs2_data, rd_in,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, kill, funct3, rs1_data, rs2_data, rd_in,
        output busy, done, result, rd_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring shift-subtract
// step per cycle over magnitudes, sign fix-up in a final cycle.
// Ports: clk, rst (async active-high), bus (slave side of muldiv_unit_if):
//   start/kill/funct3/rs1_data/rs2_data/rd_in in; busy/done/result/rd_out out.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic           clk,
    input  logic           rst,
    muldiv_unit_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam int unsigned PW    = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [2:0]      op;
    logic            neg;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] opb;
    logic [PW-1:0]   acc;
    logic [CNT_W-1:0] count;

    // Operand decode in IDLE
    logic            sign1;
    logic            sign2;
    logic            signed_a;
    logic            signed_b;
    logic            sign_in;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic            accept;

    always_comb begin
        sign1    = bus.rs1_data[XLEN-1];
        sign2    = bus.rs2_data[XLEN-1];
        signed_b = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) ||
                   (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        signed_a = signed_b || (bus.funct3 == 3'b010);
        mag1     = (signed_a && sign1) ? (XLEN'(0) - bus.rs1_data) : bus.rs1_data;
        mag2     = (signed_b && sign2) ? (XLEN'(0) - bus.rs2_data) : bus.rs2_data;
        case (bus.funct3)
            3'b000, 3'b001, 3'b100: sign_in = sign1 ^ sign2;
            3'b010, 3'b110:         sign_in = sign1;
            default:                sign_in = 1'b0;
        endcase
        div_zero = bus.funct3[2] && (bus.rs2_data == '0);
        div_ovf  = ((bus.funct3 == 3'b100) || (bus.funct3 == 3'b110)) &&
                   (bus.rs1_data == MIN_NEG) && (bus.rs2_data == '1);
        special  = div_zero || div_ovf;
        if (div_zero) begin
            special_res = bus.funct3[1] ? bus.rs1_data : '1;
        end else begin
            special_res = bus.funct3[1] ? '0 : MIN_NEG;
        end
        accept   = (state == IDLE) && bus.start && !bus.kill;
    end

    // One iteration step; acc holds {hi, lo} for both algorithms
    logic [XLEN:0]   mul_sum;
    logic [PW-1:0]   mul_step;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;
    logic [PW-1:0]   div_step;

    always_comb begin
        mul_sum  = {1'b0, acc[PW-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
        mul_step = {mul_sum, acc[XLEN-1:1]};
        rem_sh   = {acc[PW-1:XLEN], acc[XLEN-1]};
        diff     = rem_sh - {1'b0, opb};
        div_step = diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                              : {diff[XLEN-1:0],   acc[XLEN-2:0], 1'b1};
    end

    // Sign fix-up and result select
    logic [PW-1:0]   prod_fix;
    logic [XLEN-1:0] div_sel;
    logic [XLEN-1:0] fix_res;

    always_comb begin
        prod_fix = neg ? (PW'(0) - acc) : acc;
        div_sel  = op[1] ? acc[PW-1:XLEN] : acc[XLEN-1:0];
        if (op[2]) begin
            fix_res = neg ? (XLEN'(0) - div_sel) : div_sel;
        end else if (op[1:0] == 2'b00) begin
            fix_res = prod_fix[XLEN-1:0];
        end else begin
            fix_res = prod_fix[PW-1:XLEN];
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = special ? DONE : CALC;
            CALC: begin
                if (bus.kill) begin
                    state_next = IDLE;
                end else if (count == CNT_W'(XLEN - 1)) begin
                    state_next = FIX;
                end
            end
            FIX:  state_next = bus.kill ? IDLE : DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op         <= '0;
            neg        <= 1'b0;
            rd_q       <= '0;
            opb        <= '0;
            acc        <= '0;
            count      <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.result <= '0;
            bus.rd_out <= '0;
        end else begin
            bus.busy <= (state_next != IDLE);
            bus.done <= (state_next == DONE);
            if (accept) begin
                op    <= bus.funct3;
                neg   <= sign_in;
                rd_q  <= bus.rd_in;
                count <= '0;
                if (special) begin
                    bus.result <= special_res;
                    bus.rd_out <= bus.rd_in;
                end else if (bus.funct3[2]) begin
                    opb <= mag2;
                    acc <= {{XLEN{1'b0}}, mag1};
                end else begin
                    opb <= mag1;
                    acc <= {{XLEN{1'b0}}, mag2};
                end
            end else if (state == CALC) begin
                acc   <= op[2] ? div_step : mul_step;
                count <= count + CNT_W'(1);
            end else if ((state == FIX) && !bus.kill) begin
                bus.result <= fix_res;
                bus.rd_out <= rd_q;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases plus randomized
// operations compared against an arithmetic reference model.
module tb_muldiv_unit;
    localparam int unsigned XLEN     = 32;
    localparam int          MAX_WAIT = 40;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [31:0] exp_result;
    logic [4:0]  exp_rd;

    muldiv_unit_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference result straight from the RV32M definitions
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa, sb, p;
        logic [63:0] ua, ub, up;
        int sa32, sb32;
        logic ovf;
        sa   = {{32{a[31]}}, a};
        sb   = {{32{b[31]}}, b};
        ua   = {32'b0, a};
        ub   = {32'b0, b};
        sa32 = a;
        sb32 = b;
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        ref_result = '0;
        case (f3)
            3'd0: begin p = sa * sb; ref_result = p[31:0]; end
            3'd1: begin p = sa * sb; ref_result = p[63:32]; end
            3'd2: begin p = sa * $signed(ub); ref_result = p[63:32]; end
            3'd3: begin up = ua * ub; ref_result = up[63:32]; end
            3'd4: ref_result = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa32 / sb32);
            3'd5: ref_result = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: ref_result = (b == 0) ? a : ovf ? 32'h0 : 32'(sa32 % sb32);
            default: ref_result = (b == 0) ? a : a % b;
        endcase
    endfunction

    // Cycle (relative to the start cycle) in which done is expected
    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        logic ovf;
        ovf = ((f3 == 3'd4) || (f3 == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (f3[2] && ((b == 0) || ovf)) return 1;
        return XLEN + 2;
    endfunction

    // Issue one op in the current cycle and follow it through done; optional
    // ignored start pulse in cycle ign_cyc.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input int ign_cyc);
        int lat;
        int done_cyc;
        int done_cnt;
        int busy_cnt;
        logic [31:0] exp;
        lat      = ref_latency(f3, a, b);
        exp      = ref_result(f3, a, b);
        done_cyc = -1;
        done_cnt = 0;
        busy_cnt = 0;
        bus.start    = 1'b1;
        bus.funct3   = f3;
        bus.rs1_data = a;
        bus.rs2_data = b;
        bus.rd_in    = rd;
        for (int cyc = 1; cyc <= MAX_WAIT; cyc++) begin
            step();
            bus.start = 1'b0;
            if (cyc == ign_cyc) begin
                bus.start    = 1'b1;
                bus.funct3   = ~f3;
                bus.rs1_data = ~a;
                bus.rs2_data = b ^ 32'h5;
                bus.rd_in    = ~rd;
            end
            if (cyc == 1 && lat > 1) check({tag, ".held"}, bus.result, exp_result);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    check({tag, ".result"}, bus.result, exp);
                    check({tag, ".rd"}, 32'(bus.rd_out), 32'(rd));
                end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
                check({tag, ".done_once"}, 32'(done_cnt), 32'd1);
                break;
            end
        end
        bus.start = 1'b0;
        check({tag, ".done_cyc"}, 32'(done_cyc), 32'(lat));
        check({tag, ".busy_cyc"}, 32'(busy_cnt), 32'(lat));
        exp_result = exp;
        exp_rd     = rd;
    endtask

    // Start a MUL and kill it in cycle kill_cyc; returns in cycle kill_cyc+1
    task automatic run_kill(input string tag, input int kill_cyc);
        int done_cnt;
        done_cnt     = 0;
        bus.start    = 1'b1;
        bus.funct3   = 3'd0;
        bus.rs1_data = 32'd1234;
        bus.rs2_data = 32'd5678;
        bus.rd_in    = 5'd17;
        for (int cyc = 1; cyc <= kill_cyc; cyc++) begin
            step();
            bus.start = 1'b0;
            bus.kill  = (cyc == kill_cyc);
            if (bus.done) done_cnt++;
        end
        step();
        bus.kill = 1'b0;
        if (bus.done) done_cnt++;
        check({tag, ".busy"}, 32'(bus.busy), 32'd0);
        check({tag, ".no_done"}, 32'(done_cnt), 32'd0);
        check({tag, ".result"}, bus.result, exp_result);
        check({tag, ".rd"}, 32'(bus.rd_out), 32'(exp_rd));
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    logic [2:0]  r_f3;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_rd;

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        exp_result   = '0;
        exp_rd       = '0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.kill     = 1'b0;
        bus.funct3   = '0;
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        bus.rd_in    = '0;
        step();
        step();
        check("reset.busy", 32'(bus.busy), 32'd0);
        check("reset.done", 32'(bus.done), 32'd0);
        check("reset.result", bus.result, 32'd0);
        check("reset.rd", 32'(bus.rd_out), 32'd0);
        rst = 1'b0;
        step();

        run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0);
        run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 0);
        run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);
        run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 0);
        run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 0);
        run_op("divu", 3'd5, 32'd100, 32'd7, 5'd7, 0);
        run_op("remu", 3'd7, 32'd100, 32'd7, 5'd8, 0);
        run_op("div0", 3'd4, 32'd5, 32'd0, 5'd9, 0);
        run_op("rem0", 3'd6, 32'd5, 32'd0, 5'd10, 0);
        run_op("divu0", 3'd5, 32'd5, 32'd0, 5'd11, 0);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0);

        run_op("ign_start", 3'd0, 32'd3, 32'd4, 5'd14, 5);
        run_kill("kill_calc", 10);
        run_op("after_kill", 3'd5, 32'd1000, 32'd9, 5'd15, 0);
        run_kill("kill_fix", XLEN + 1);
        run_op("after_kill_fix", 3'd1, 32'h1234_5678, 32'hFEDC_BA98, 5'd16, 0);

        // kill and start together in IDLE: start must not be taken
        bus.start    = 1'b1;
        bus.kill     = 1'b1;
        bus.funct3   = 3'd5;
        bus.rs1_data = 32'd50;
        bus.rs2_data = 32'd0;
        bus.rd_in    = 5'd20;
        step();
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        check("kill_start.busy", 32'(bus.busy), 32'd0);
        check("kill_start.done", 32'(bus.done), 32'd0);
        check("kill_start.result", bus.result, exp_result);

        for (int i = 0; i < 40; i++) begin
            r_f3 = 3'($urandom_range(0, 7));
            r_a  = pick_operand();
            r_b  = pick_operand();
            r_rd = 5'($urandom_range(0, 31));
            run_op($sformatf("rand%0d_f%0d", i, r_f3), r_f3, r_a, r_b, r_rd, 0);
        end

        // Asynchronous reset in the middle of a divide
        run_op("pre_reset", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0);
        bus.start    = 1'b1;
        bus.funct3   = 3'd4;
        bus.rs1_data = 32'hFFFF_FF9C;
        bus.rs2_data = 32'd7;
        bus.rd_in    = 5'd21;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            step();
            bus.start = 1'b0;
        end
        #2;
        rst = 1'b1;
        #1;
        check("async_rst.busy", 32'(bus.busy), 32'd0);
        check("async_rst.done", 32'(bus.done), 32'd0);
        check("async_rst.result", bus.result, 32'd0);
        check("async_rst.rd", 32'(bus.rd_out), 32'd0);
        step();
        rst = 1'b0;
        exp_result = '0;
        exp_rd     = '0;
        step();
        run_op("post_reset", 3'd5, 32'd9, 32'd3, 5'd22, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit for the multi-cycle core. Sits directly downstream of the register file and consumes its two read ports (read_data1/read_data2) as operands. The result and destination index feed the writeback path into the register file's data_in/Rd/we. The control FSM stalls on busy and commits on the one-cycle done pulse.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
kill  input  1  synchronous abort of an in-flight operation.
funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
rs1_data  input  XLEN  operand A, from register file read_data1.
rs2_data  input  XLEN  operand B, from register file read_data2.
rd_in  input  5  destination register index, captured with the operands.
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse; result and rd_out are valid.
result  output  XLEN  registered result; held until the next accepted start.
rd_out  output  5  captured rd_in, for writeback.

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE; busy=0, done=0, result=0, rd_out=0; all internal accumulators and counters cleared. The in-flight operation is discarded.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1: latch funct3, rd_in, and magnitude operands.
  - Signed ops take absolute values.
  - MULHSU takes only the rs1 magnitude.
  - Record the result sign: MUL/MULH sign = sign1^sign2; MULHSU sign = sign1; DIV sign = sign1^sign2; REM sign = sign1.
- IDLE special cases, go straight to DONE with result loaded:
  - Divide by zero (rs2=0): DIV/DIVU result = all ones; REM/REMU result = rs1.
  - Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): DIV result = 0x80000000; REM result = 0.
- IDLE, otherwise: go to CALC with count=0.
- CALC, one iteration per cycle, exactly XLEN cycles, then go to FIX:
  - Multiply: shift-add into a 2*XLEN product.
  - Divide: restoring shift-subtract, producing quotient and remainder.
- FIX (1 cycle): apply two's-complement negation if the recorded sign is set.
  - Select the low XLEN bits for MUL, the high XLEN bits for MULH/MULHSU/MULHU.
  - Select the quotient for DIV/DIVU, the remainder for REM/REMU.
  - Write result and go to DONE.
- DONE (1 cycle): done=1. Always returns to IDLE next cycle; start is ignored in DONE.
- Latency, with start accepted in cycle 0:
  - Normal op: busy high cycles 1..XLEN+2; done high in cycle XLEN+2 (34).
  - Special case: done and busy high in cycle 1.
  - Next start can be accepted in cycle XLEN+3 (normal) or cycle 2 (special).
- start while busy: ignored; no state change and no operand capture.
- kill: in CALC or FIX, go to IDLE next cycle with no done pulse; result keeps its previous value. kill in IDLE or DONE has no effect. kill and start together in IDLE: kill wins, start is not accepted.
- Arithmetic is modulo 2^XLEN; negating 0x80000000 yields 0x80000000.
- done never asserts twice for one start.
- result and rd_out change only on the FIX or special-case load.

Test Plan:
1. MUL 7 × 0xFFFFFFFD (-3), rd_in=5, start in cycle 0 -> busy=1 in cycles 1–34; done=1 only in cycle 34; result=0xFFFFFFEB; rd_out=5.
2. High multiplies:
   - MULH 0x80000000×0x80000000 -> 0x40000000.
   - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
3. Divides:
   - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
   - DIVU 100/7 -> 14; REMU 100/7 -> 2.
   - Each has done in cycle 34.
4. Special cases:
   - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIVU 5/0 -> 0xFFFFFFFF.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
   - All have done in cycle 1.
5. Busy and kill:
   - start a MUL; pulse start with other operands at cycle 5 -> ignored, result is the original product.
   - Separately, kill at cycle 10 -> busy=0 from cycle 11, no done pulse, result unchanged; a new start in cycle 11 completes normally.
6. Reset mid-operation: assert rst asynchronously mid-cycle 15 of a DIV -> busy, done, result, rd_out go to 0 immediately without a clock edge. After release, a fresh DIVU 9/3 returns 3.
